// File: rtl/tcm3_serial_scheduler_pkg.sv
// Shared definitions for the serial 3-way split GF(2) multiplier: default sizes,
// scheduler states and the limb-pair schedule with its fold offsets.
package tcm3_pkg;

  localparam int N_DEF     = 409;
  localparam int K_DEF     = 137;
  localparam int NUM_PAIRS = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Pairs are ordered by ascending fold offset.
  localparam logic [1:0] PAIR_I [NUM_PAIRS] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
  localparam logic [1:0] PAIR_J [NUM_PAIRS] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2};
  localparam int OFFSET [NUM_PAIRS] = '{0, K_DEF, K_DEF, 2*K_DEF, 2*K_DEF, 2*K_DEF,
                                        3*K_DEF, 3*K_DEF, 4*K_DEF};

  // Same offsets as OFFSET, but for an arbitrary limb width k.
  function automatic int pair_offset(input logic [3:0] p, input int k);
    return (int'(PAIR_I[p]) + int'(PAIR_J[p])) * k;
  endfunction

endpackage

// File: rtl/tcm3_serial_scheduler_mac.sv
// Bit-serial K x K carry-less multiply-accumulate: one multiplicand bit per
// enabled cycle, with limb selection from the latched full-width operands.
module gf2_serial_mac #(
  parameter int N = 409,
  parameter int K = 137
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [1:0]       sel_i,
  input  logic [1:0]       sel_j,
  input  logic             en,
  input  logic             clr,
  output logic [2*K-2:0]   acc,
  output logic             last
);

  localparam int BW    = $clog2(K);
  localparam int ACC_W = 2*K - 1;

  logic [K-1:0]  ai;
  logic [K-1:0]  bj;
  logic [BW-1:0] bit_cnt;

  // Top limb is narrower than K and is zero-extended.
  function automatic logic [K-1:0] limb(input logic [N-1:0] x, input logic [1:0] s);
    case (s)
      2'd0:    return x[K-1:0];
      2'd1:    return x[2*K-1:K];
      default: return K'(x[N-1:2*K]);
    endcase
  endfunction

  assign ai   = limb(a, sel_i);
  assign bj   = limb(b, sel_j);
  assign last = (bit_cnt == BW'(K-1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      if (ai[bit_cnt]) acc <= acc ^ (ACC_W'(bj) << bit_cnt);
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/tcm3_serial_scheduler.sv
// Scheduler for one N x N GF(2) product in 3-way split form: runs the nine
// limb-pair products one at a time on a shared serial MAC and folds them in.
module tcm3_serial_scheduler
  import tcm3_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   c,
  output logic             busy
);

  localparam int RES_W = 2*N;
  localparam int ACC_W = 2*K - 1;

  if ((2*K >= N) || (N > 3*K)) begin : g_bad_params
    $error("tcm3_serial_scheduler: limb width K must satisfy 2K < N <= 3K");
  end

  state_t             state, state_nxt;
  logic [3:0]         p;
  logic [N-1:0]       a_q, b_q;
  logic [RES_W-1:0]   res;
  logic [ACC_W-1:0]   acc;
  logic               mac_en, mac_clr, mac_last;
  logic               accept, fold_now;

  gf2_serial_mac #(.N(N), .K(K)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .a     (a_q),
    .b     (b_q),
    .sel_i (PAIR_I[p]),
    .sel_j (PAIR_J[p]),
    .en    (mac_en),
    .clr   (mac_clr),
    .acc   (acc),
    .last  (mac_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = MUL;
      MUL:  if (abort) state_nxt = IDLE;
            else if (mac_last) state_nxt = FOLD;
      FOLD: if (abort) state_nxt = IDLE;
            else if (p == 4'(NUM_PAIRS-1)) state_nxt = DONE;
            else state_nxt = MUL;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Abort only matters while an operation is in flight; FOLD always empties the MAC.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == MUL) || (state == FOLD);
    accept    = (state == IDLE) && in_valid;
    mac_en    = (state == MUL) && !abort;
    fold_now  = (state == FOLD) && !abort;
    mac_clr   = accept || (state == FOLD) || ((state == MUL) && abort);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p   <= '0;
      res <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      p   <= '0;
      res <= '0;
    end else if (fold_now) begin
      res <= res ^ (RES_W'(acc) << pair_offset(p, K));
      if (p != 4'(NUM_PAIRS-1)) p <= p + 4'd1;
    end
  end

  assign c = res;

endmodule

// File: tb/tb_tcm3_serial_scheduler.sv
// Directed bench for tcm3_serial_scheduler: table of operand pairs with
// hand-computed products, plus backpressure, abort and reset sequences.
module tb_tcm3_serial_scheduler;

  localparam int N   = 409;
  localparam int K   = 137;
  localparam int LAT = 9*(K+1);

  typedef logic [N-1:0]   op_t;
  typedef logic [2*N-1:0] res_t;

  typedef struct {
    string name;
    op_t   a;
    op_t   b;
    res_t  c;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  op_t  a = '0;
  op_t  b = '0;
  logic abort = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  res_t c;
  logic busy;

  int n_pass  = 0;
  int n_total = 0;

  tcm3_serial_scheduler #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input res_t got, input res_t exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", name, got, exp);
  endtask

  // Offer one operand pair from IDLE; return the edge count to out_valid and c.
  task automatic run_op(input op_t ai, input op_t bi, output res_t got, output int cyc);
    @(negedge clk);
    a = ai; b = bi; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
    end
    got = c;
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({name, "_ov_drop"}, res_t'(out_valid), res_t'(0));
    check({name, "_idle"},    res_t'(in_ready),  res_t'(1));
  endtask

  initial begin
    vec_t vecs[8];
    op_t  top_bit, ones;
    res_t got, held;
    int   cyc;
    logic stable, ready_low, seen_valid;

    top_bit = op_t'(1) << (N-1);
    ones    = '1;
    vecs[0] = '{"one",          op_t'(1),             op_t'(1),             res_t'(1)};
    vecs[1] = '{"three",        op_t'(3),             op_t'(3),             res_t'(5)};
    vecs[2] = '{"top_sq",       top_bit,              top_bit,              res_t'(1) << (2*N-2)};
    vecs[3] = '{"ones_x1",      ones,                 op_t'(1),             {{N{1'b0}}, ones}};
    vecs[4] = '{"limb_edge",    op_t'(1) << (K-1),    op_t'(1) << K,        res_t'(1) << (2*K-1)};
    vecs[5] = '{"mid_high",     op_t'(1) << K,        op_t'(1) << (2*K),    res_t'(1) << (3*K)};
    vecs[6] = '{"cross_cancel", top_bit | op_t'(1),   top_bit | op_t'(1),   (res_t'(1) << (2*N-2)) | res_t'(1)};
    vecs[7] = '{"five_seven",   op_t'(5),             op_t'(7),             res_t'(27)};

    #12;
    check("rst_in_ready",  res_t'(in_ready),  res_t'(1));
    check("rst_out_valid", res_t'(out_valid), res_t'(0));
    check("rst_busy",      res_t'(busy),      res_t'(0));
    check("rst_c",         c,                 res_t'(0));
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, got, cyc);
      check({vecs[i].name, "_latency"}, res_t'(cyc), res_t'(LAT));
      check(vecs[i].name, got, vecs[i].c);
      if (i == 0) begin
        held = c; stable = 1'b1; ready_low = 1'b1;
        repeat (50) begin
          @(posedge clk);
          #1;
          if (c !== held || !out_valid) stable = 1'b0;
          if (in_ready !== 1'b0) ready_low = 1'b0;
        end
        check("bp_c_stable",   res_t'(stable),    res_t'(1));
        check("bp_in_ready_0", res_t'(ready_low), res_t'(1));
      end
      release_result(vecs[i].name);
    end

    // Abort at cycle 600 of an operation, then a fresh operation.
    @(negedge clk);
    a = op_t'(1) << 200; b = ones; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (599) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_idle",  res_t'(in_ready), res_t'(1));
    check("abort_busy",  res_t'(busy),     res_t'(0));
    seen_valid = 1'b0;
    repeat (1300) begin
      @(posedge clk);
      #1 if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_out", res_t'(seen_valid), res_t'(0));
    run_op(op_t'(5), op_t'(7), got, cyc);
    check("post_abort_latency", res_t'(cyc), res_t'(LAT));
    check("post_abort_c",       got,         res_t'(27));
    release_result("post_abort");

    // Asynchronous reset mid-MUL, after pair 0 has already folded into c.
    @(negedge clk);
    a = op_t'(5); b = op_t'(7); in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (299) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready",  res_t'(in_ready),  res_t'(1));
    check("midrst_out_valid", res_t'(out_valid), res_t'(0));
    check("midrst_busy",      res_t'(busy),      res_t'(0));
    check("midrst_c",         c,                 res_t'(0));
    #2 rst = 1'b0;
    run_op(top_bit | op_t'(1), top_bit | op_t'(1), got, cyc);
    check("post_rst_latency", res_t'(cyc), res_t'(LAT));
    check("post_rst_c",       got,         (res_t'(1) << (2*N-2)) | res_t'(1));
    release_result("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
